// File: rtl/game_controller.sv
// Pong match sequencer: scores, serve timing and ball gating on the pixel clock.
// Optional attract mode after game over is built only when ATTRACT_EN is defined.
module game_controller #(
    parameter int WIN_SCORE      = 11,
    parameter int SERVE_FRAMES   = 60,
    parameter int ATTRACT_FRAMES = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vblank,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic       game_over
);

    if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_win_range
        $error("WIN_SCORE must be 1..15");
    end
    if (SERVE_FRAMES < 1 || SERVE_FRAMES > 255) begin : g_serve_range
        $error("SERVE_FRAMES must be 1..255");
    end
    if (ATTRACT_FRAMES < 1 || ATTRACT_FRAMES > 255) begin : g_attract_range
        $error("ATTRACT_FRAMES must be 1..255");
    end

    localparam logic [3:0] WIN_N   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
`ifdef ATTRACT_EN
    localparam logic [7:0] ATTRACT_N = 8'(ATTRACT_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER, S_ATTRACT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER
    } state_t;
`endif

    state_t     state_q;
    logic       armed_q;
    logic       vblank_q;
    logic       start_q;
    logic [7:0] frame_cnt_q;
    logic [3:0] left_q;
    logic [3:0] right_q;
    logic       ball_en_q;
    logic       serve_dir_q;
    logic       game_over_q;

    logic       frame_tick;
    logic       start_edge;
    logic [7:0] frame_cnt_inc;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // armed_q masks the first cycle after reset so a level already high is not an edge
    assign frame_tick    = armed_q & vblank & ~vblank_q;
    assign start_edge    = armed_q & start & ~start_q;
    assign frame_cnt_inc = frame_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            vblank_q    <= 1'b0;
            start_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            left_q      <= 4'd0;
            right_q     <= 4'd0;
            ball_en_q   <= 1'b0;
            serve_dir_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            armed_q  <= 1'b1;
            vblank_q <= vblank;
            start_q  <= start;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_edge) begin
                        left_q      <= 4'd0;
                        right_q     <= 4'd0;
                        serve_dir_q <= 1'b0;
                        game_over_q <= 1'b0;
                        frame_cnt_q <= 8'd0;
                        state_q     <= S_SERVE;
                    end
`ifdef ATTRACT_EN
                    else if (state_q == S_OVER && frame_tick) begin
                        frame_cnt_q <= frame_cnt_inc;
                        if (frame_cnt_inc == ATTRACT_N) begin
                            ball_en_q <= 1'b1;
                            state_q   <= S_ATTRACT;
                        end
                    end
`endif
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        frame_cnt_q <= frame_cnt_inc;
                        if (frame_cnt_inc == SERVE_N) begin
                            ball_en_q <= 1'b1;
                            state_q   <= S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    // a double miss is a let: nobody scores, serve side kept
                    if (miss_left | miss_right) begin
                        ball_en_q <= 1'b0;
                        state_q   <= S_POINT;
                        if (miss_right && !miss_left) begin
                            left_q      <= sat_inc(left_q);
                            serve_dir_q <= 1'b0;
                        end else if (miss_left && !miss_right) begin
                            right_q     <= sat_inc(right_q);
                            serve_dir_q <= 1'b1;
                        end
                    end
                end
                S_POINT: begin
                    frame_cnt_q <= 8'd0;
                    if (left_q == WIN_N || right_q == WIN_N) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                    end else begin
                        state_q <= S_SERVE;
                    end
                end
`ifdef ATTRACT_EN
                S_ATTRACT: begin
                    if (start_edge) begin
                        left_q      <= 4'd0;
                        right_q     <= 4'd0;
                        serve_dir_q <= 1'b0;
                        game_over_q <= 1'b0;
                        ball_en_q   <= 1'b0;
                        frame_cnt_q <= 8'd0;
                        state_q     <= S_SERVE;
                    end else if (!ball_en_q) begin
                        ball_en_q <= 1'b1;
                    end else if (miss_left | miss_right) begin
                        serve_dir_q <= ~serve_dir_q;
                        ball_en_q   <= 1'b0;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign left_score  = left_q;
    assign right_score = right_q;
    assign ball_enable = ball_en_q;
    assign serve_dir   = serve_dir_q;
    assign game_over   = game_over_q;

endmodule
